hex_score_ctrl: RTL and testbench

HEX_SCORE_CTRL -- requirements
Module: hex_score_ctrl

---
 rtl/hex_score_ctrl_pkg.sv | 57 +++++
 rtl/hex_seg_decode.sv | 14 +
 rtl/hex_score_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hex_score_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_score_ctrl_pkg.sv
// Shared types and constants for the hex score display controller:
// FSM states, register map, bit indices, saturation limit and segment codes.
package hex_score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_LZ_BLANK  = 1;
  localparam int CTRL_BLINK     = 2;
  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_PENDING = 1;

  localparam int unsigned VALUE_MAX = 999999;
  localparam int          NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry n is the code for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_BLANK;
    return SEG_TABLE[digit];
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [23:0] bcd_adjust(input logic [23:0] bcd);
    logic [23:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// One BCD digit to active-low 7-segment code, with a forced-blank input.
module hex_seg_decode
  import hex_score_ctrl_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_bcd);
  end

endmodule

// File: rtl/hex_score_ctrl.sv
// Avalon-MM score register with serial binary-to-BCD conversion (double-dabble)
// driving six registered 7-segment digits with enable, leading-zero blank and blink.
module hex_score_ctrl
  import hex_score_ctrl_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int VAL_W     = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int SHIFT_CNT_W = $clog2(VAL_W + 1);
  localparam int BLINK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = SHIFT_CNT_W'(VAL_W - 1);
  localparam logic [BLINK_W-1:0]     BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [VAL_W-1:0]       r_value;
  logic [2:0]             r_ctrl;
  logic                   r_pending;
  state_e                 r_state;
  logic [VAL_W-1:0]       r_bin;
  logic [23:0]            r_bcd;
  logic [SHIFT_CNT_W-1:0] r_shift_cnt;
  logic [23:0]            r_disp;
  logic [BLINK_W-1:0]     r_blink_cnt;
  logic                   r_phase;
  logic [6:0]             r_hex [NUM_DIGITS];

  logic                   w_wr;
  logic                   w_wr_value;
  logic                   w_wr_ctrl;
  logic                   w_busy;
  logic [VAL_W-1:0]       w_value_sat;
  logic [24+VAL_W-1:0]    w_shift;
  logic [5:1]             w_lead_zero;
  logic [NUM_DIGITS-1:0]  w_blank;
  logic [6:0]             w_seg [NUM_DIGITS];

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_value  = w_wr && (address == ADDR_VALUE);
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_value_sat = (writedata > 32'(VALUE_MAX)) ? VAL_W'(VALUE_MAX) : writedata[VAL_W-1:0];
  assign w_shift     = {bcd_adjust(r_bcd), r_bin} << 1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
      r_ctrl  <= '0;
    end else begin
      if (w_wr_value) r_value <= w_value_sat;
      if (w_wr_ctrl)  r_ctrl  <= writedata[2:0];
    end
  end

  // Conversion FSM. A write seen in IDLE launches directly; writes in any
  // busy state (including LOAD, where the set beats the clear) leave PENDING.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_shift_cnt <= '0;
      r_disp      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_value || r_pending) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_bin       <= r_value;
          r_bcd       <= '0;
          r_shift_cnt <= '0;
          r_pending   <= w_wr_value;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= w_shift;
          r_shift_cnt    <= r_shift_cnt + 1'b1;
          if (w_wr_value) r_pending <= 1'b1;
          if (r_shift_cnt == SHIFT_LAST) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_disp  <= r_bcd;
          if (w_wr_value) r_pending <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (!r_ctrl[CTRL_BLINK]) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // w_lead_zero[i]: digit i and every digit above it are zero.
  assign w_lead_zero[5] = (r_disp[23:20] == 4'd0);
  for (genvar g = 4; g >= 1; g--) begin : g_lz
    assign w_lead_zero[g] = w_lead_zero[g+1] && (r_disp[4*g +: 4] == 4'd0);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_units
      assign w_blank[g] = ~r_ctrl[CTRL_ENABLE] | r_phase;
    end else begin : g_upper
      assign w_blank[g] = ~r_ctrl[CTRL_ENABLE] | r_phase
                        | (r_ctrl[CTRL_LZ_BLANK] & w_lead_zero[g]);
    end

    hex_seg_decode u_dec (
      .i_bcd   (r_disp[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[g])
    );
  end

  // NOTE: the segment array is small and must come up dark, so it is reset
  // like any other register; large storage arrays would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_hex[i] <= SEG_BLANK;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) r_hex[i] <= w_seg[i];
    end
  end

  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];

  // NOTE: readdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_VALUE:  readdata = 32'(r_value);
      ADDR_CTRL:   readdata = 32'(r_ctrl);
      ADDR_STATUS: readdata = 32'({r_pending, w_busy});
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hex_score_ctrl.sv
// Self-checking bench for hex_score_ctrl: randomized register traffic compared
// against a decimal-arithmetic model of the display.
module tb_hex_score_ctrl;

  localparam int BLINK_DIV = 4;
  localparam int VAL_W     = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] disp_now;

  int checks = 0;
  int errors = 0;

  hex_score_ctrl #(.BLINK_DIV(BLINK_DIV), .VAL_W(VAL_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5)
  );

  always #5 clk = ~clk;
  assign disp_now = {hex5, hex4, hex3, hex2, hex1, hex0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int unsigned sat(input logic [31:0] w);
    return (w > 32'd999999) ? 999999 : int'(w);
  endfunction

  // Expected {hex5..hex0} for a stored value and CTRL, blink phase off.
  function automatic logic [41:0] exp_disp(input int unsigned v, input logic [2:0] c);
    logic [41:0]  r;
    int unsigned  p;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (!c[0])                        r[7*i +: 7] = 7'h7F;
      else if (c[1] && i != 0 && v < p) r[7*i +: 7] = 7'h7F;
      else                              r[7*i +: 7] = seg_ref(int'((v / p) % 10));
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic bus_write_raw(input logic cs, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = cs;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd2;
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_write_raw(1'b1, a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = 2'd2;
    #1;
  endtask

  // Waits until neither busy nor pending, then one more edge for the hex registers.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    address = 2'd2;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (readdata[1:0] == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_value(input logic [31:0] v, input string name);
    bit ok;
    bus_write(2'd0, v);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: busy never cleared", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd2; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (disp_now !== {6{7'h7F}}) begin
      errors++; $display("FAIL reset_hex: got %h want %h", disp_now, {6{7'h7F}});
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL reset_reg%0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd123456);
    for (int k = 0; k <= 23; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (readdata[0]) busy_cnt++;
      if (k == 22) begin
        checks++;
        if (disp_now !== exp_disp(0, 3'd1)) begin
          errors++; $display("FAIL basic_early: got %h want %h", disp_now, exp_disp(0, 3'd1));
        end
      end
      if (k == 23) begin
        checks++;
        if (disp_now !== exp_disp(123456, 3'd1)) begin
          errors++; $display("FAIL basic_disp: got %h want %h", disp_now, exp_disp(123456, 3'd1));
        end
      end
    end
    checks++;
    if (busy_cnt != 22) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d want 22", busy_cnt);
    end
    checks++;
    if (hex0 !== 7'b0000010) begin
      errors++; $display("FAIL basic_hex0: got %b want 0000010", hex0);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    logic [31:0] vals [3] = '{32'd1000000, 32'hFFFF_FFFF, 32'd999999};
    foreach (vals[i]) begin
      run_value(vals[i], "sat");
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'(sat(vals[i]))) begin
        errors++; $display("FAIL sat_value[%0d]: got %0d want %0d", i, d, sat(vals[i]));
      end
      checks++;
      if (disp_now !== exp_disp(999999, 3'd1)) begin
        errors++; $display("FAIL sat_disp[%0d]: got %h want %h", i, disp_now, exp_disp(999999, 3'd1));
      end
    end
  endtask

  task automatic test_lz_blank();
    int unsigned vals [4] = '{42, 0, 100000, 7008};
    bus_write(2'd1, 32'd3);
    foreach (vals[i]) begin
      run_value(vals[i], "lz");
      checks++;
      if (disp_now !== exp_disp(vals[i], 3'd3)) begin
        errors++; $display("FAIL lz_disp[%0d]: got %h want %h", vals[i], disp_now, exp_disp(vals[i], 3'd3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int starts;
    bit prev, done;
    logic [31:0] d;
    bus_write(2'd1, 32'd1);
    // 222 lands on the LOAD cycle of the first conversion.
    bus_write(2'd0, 32'd111);
    bus_write(2'd0, 32'd222);
    bus_write(2'd0, 32'd333);
    checks++;
    if (readdata[1:0] !== 2'b11) begin
      errors++; $display("FAIL b2b_status: got %b want 11", readdata[1:0]);
    end
    starts = 1; prev = 1'b1; done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (readdata[0] && !prev) starts++;
      prev = readdata[0];
      if (readdata[1:0] == 2'b00) begin done = 1'b1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!done || starts != 2) begin
      errors++; $display("FAIL b2b_conversions: got %0d (done=%0d) want 2", starts, done);
    end
    checks++;
    if (disp_now !== exp_disp(333, 3'd1)) begin
      errors++; $display("FAIL b2b_disp: got %h want %h", disp_now, exp_disp(333, 3'd1));
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'd333) begin
      errors++; $display("FAIL b2b_value: got %0d want 333", d);
    end
    // Write only on the LOAD cycle: its PENDING set must survive the LOAD clear.
    bus_write(2'd0, 32'd500);
    bus_write(2'd0, 32'd600);
    checks++;
    if (readdata[1] !== 1'b1) begin
      errors++; $display("FAIL load_pending: got %b want 1", readdata[1]);
    end
    wait_idle(done);
    checks++;
    if (!done || disp_now !== exp_disp(600, 3'd1)) begin
      errors++; $display("FAIL load_disp: got %h want %h", disp_now, exp_disp(600, 3'd1));
    end
  endtask

  task automatic test_bus();
    logic [31:0] d;
    bus_write(2'd0, 32'd4321);
    run_value(32'd4321, "bus");
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write_raw(1'b0, 2'd0, 32'd77);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL bus_addr3: got %h want 0", d);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'd4321 || readdata[0] !== 1'b0) begin
      errors++; $display("FAIL bus_ignored: got %0d busy=%b want 4321 busy=0", d, readdata[0]);
    end
    bus_write(2'd1, 32'hFFFF_FFF6);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'd6) begin
      errors++; $display("FAIL bus_ctrl: got %h want 6", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, v;
    logic [2:0]  c;
    logic [2:0]  ctrl_opts [3] = '{3'd0, 3'd1, 3'd3};
    for (int i = 0; i < 10; i++) begin
      v = 32'($urandom_range(0, 1_200_000));
      if (i % 4 == 3) v = 32'($urandom_range(0, 999));
      c = ctrl_opts[$urandom_range(0, 2)];
      bus_write(2'd1, 32'(c));
      run_value(v, "rand");
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'(sat(v)) || disp_now !== exp_disp(sat(v), c)) begin
        errors++;
        $display("FAIL rand[%0d] v=%0d ctrl=%0d: value %0d disp %h want %0d %h",
                 i, v, c, d, disp_now, sat(v), exp_disp(sat(v), c));
      end
    end
  endtask

  task automatic test_blink();
    bit blank [40];
    int toggles [$];
    int bad_shown = 0;
    int bad_steady = 0;
    bus_write(2'd1, 32'd1);
    run_value(32'd987654, "blink");
    bus_write(2'd1, 32'd7);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      blank[k] = (disp_now === {6{7'h7F}});
      if (!blank[k] && disp_now !== exp_disp(987654, 3'd3)) bad_shown++;
      if (k > 0 && blank[k] != blank[k-1]) toggles.push_back(k);
    end
    checks++;
    if (toggles.size() < 6 || bad_shown != 0) begin
      errors++; $display("FAIL blink_toggles: got %0d toggles, %0d bad frames", toggles.size(), bad_shown);
    end
    for (int i = 1; i < toggles.size(); i++) begin
      checks++;
      if (toggles[i] - toggles[i-1] != BLINK_DIV) begin
        errors++; $display("FAIL blink_period[%0d]: got %0d want %0d", i, toggles[i] - toggles[i-1], BLINK_DIV);
      end
    end
    bus_write(2'd1, 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (disp_now !== exp_disp(987654, 3'd1)) bad_steady++;
    end
    checks++;
    if (bad_steady != 0) begin
      errors++; $display("FAIL blink_off: got %0d bad frames want 0", bad_steady);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic [31:0] d;
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd555555);
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (disp_now !== {6{7'h7F}} || readdata[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_immediate: got %h busy=%b want blank busy=0", disp_now, readdata[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (disp_now !== {6{7'h7F}} || readdata[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstmid_after: got %0d non-blank/busy cycles want 0", bad);
    end
    bus_write(2'd1, 32'd1);
    @(posedge clk); #1;
    bus_read(2'd0, d);
    checks++;
    if (disp_now !== exp_disp(0, 3'd1) || d !== 32'd0) begin
      errors++; $display("FAIL rstmid_no_commit: got %h value %0d want %h value 0", disp_now, d, exp_disp(0, 3'd1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_lz_blank();
    test_back_to_back();
    test_bus();
    test_random();
    test_blink();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
